// File: rtl/csr_unit.sv
// Control/status register unit: scratch registers plus cycle/instret counters, read-old-value semantics.
// Latency 1 cycle (rdata/rvalid/illegal registered); accepts one access per cycle, no backpressure.
module csr_unit #(
  parameter int XLEN        = 32,
  parameter int NUM_SCRATCH = 4,
  parameter int CNT_WIDTH   = 64,
  parameter int HAS_INSTRET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_rvalid,
  output logic            csr_illegal
);

  localparam int PW = 2 * XLEN;
  localparam bit HAS_HI = (CNT_WIDTH > XLEN);
  localparam bit HAS_IR = (HAS_INSTRET != 0);
  localparam logic [11:0] SCR_BASE = 12'h340;

  typedef enum logic [1:0] {OP_NONE, OP_RW, OP_SET, OP_CLR} csr_op_e;

  logic [XLEN-1:0]      scratch [NUM_SCRATCH];
  logic [CNT_WIDTH-1:0] mcycle, minstret, mcycle_nxt, minstret_nxt;
  logic [PW-1:0]        mcycle_pad, minstret_pad;

  logic                   hit, ro, wr_req, illegal, do_write;
  logic [XLEN-1:0]        old_val, new_val;
  logic [NUM_SCRATCH-1:0] scr_sel;
  logic                   sel_mc_lo, sel_mc_hi, sel_mi_lo, sel_mi_hi;

  // Counters are viewed zero-extended to two words so both halves slice uniformly.
  assign mcycle_pad   = PW'(mcycle);
  assign minstret_pad = PW'(minstret);

  always_comb begin
    hit       = 1'b0;
    ro        = 1'b0;
    old_val   = '0;
    scr_sel   = '0;
    sel_mc_lo = 1'b0;
    sel_mc_hi = 1'b0;
    sel_mi_lo = 1'b0;
    sel_mi_hi = 1'b0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (csr_addr == SCR_BASE + 12'(i)) begin
        hit        = 1'b1;
        scr_sel[i] = 1'b1;
        old_val    = scratch[i];
      end
    end
    case (csr_addr)
      12'hB00: begin hit = 1'b1; sel_mc_lo = 1'b1; old_val = mcycle_pad[XLEN-1:0]; end
      12'hC00: begin hit = 1'b1; ro = 1'b1;        old_val = mcycle_pad[XLEN-1:0]; end
      12'hB80: if (HAS_HI) begin hit = 1'b1; sel_mc_hi = 1'b1; old_val = mcycle_pad[PW-1:XLEN]; end
      12'hC80: if (HAS_HI) begin hit = 1'b1; ro = 1'b1;        old_val = mcycle_pad[PW-1:XLEN]; end
      12'hB02: if (HAS_IR) begin hit = 1'b1; sel_mi_lo = 1'b1; old_val = minstret_pad[XLEN-1:0]; end
      12'hC02: if (HAS_IR) begin hit = 1'b1; ro = 1'b1;        old_val = minstret_pad[XLEN-1:0]; end
      12'hB82: if (HAS_IR && HAS_HI) begin hit = 1'b1; sel_mi_hi = 1'b1; old_val = minstret_pad[PW-1:XLEN]; end
      12'hC82: if (HAS_IR && HAS_HI) begin hit = 1'b1; ro = 1'b1;        old_val = minstret_pad[PW-1:XLEN]; end
      default: ;
    endcase
  end

  // SET/CLR with a zero mask is a pure read, which keeps read-only CSRs readable via csrrs x0.
  assign wr_req   = (csr_op == OP_RW) ||
                    (((csr_op == OP_SET) || (csr_op == OP_CLR)) && (csr_wdata != '0));
  assign illegal  = !hit || (ro && wr_req);
  assign do_write = csr_en && !illegal && wr_req;

  always_comb begin
    new_val = old_val;
    case (csr_op)
      OP_RW:   new_val = csr_wdata;
      OP_SET:  new_val = old_val | csr_wdata;
      OP_CLR:  new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  // A written half replaces the increment; the other half keeps its start-of-cycle value.
  always_comb begin
    mcycle_nxt = mcycle + CNT_WIDTH'(1);
    if (do_write && sel_mc_lo)
      mcycle_nxt = CNT_WIDTH'({mcycle_pad[PW-1:XLEN], new_val});
    else if (do_write && sel_mc_hi)
      mcycle_nxt = CNT_WIDTH'({new_val, mcycle_pad[XLEN-1:0]});

    minstret_nxt = minstret + CNT_WIDTH'(instr_retire);
    if (do_write && sel_mi_lo)
      minstret_nxt = CNT_WIDTH'({minstret_pad[PW-1:XLEN], new_val});
    else if (do_write && sel_mi_hi)
      minstret_nxt = CNT_WIDTH'({new_val, minstret_pad[XLEN-1:0]});
    if (!HAS_IR)
      minstret_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle      <= '0;
      minstret    <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
      csr_illegal <= 1'b0;
    end else begin
      mcycle   <= mcycle_nxt;
      minstret <= minstret_nxt;
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (do_write && scr_sel[i]) scratch[i] <= new_val;
      end
      csr_rvalid  <= csr_en;
      csr_illegal <= csr_en && illegal;
      if (csr_en) csr_rdata <= illegal ? '0 : old_val;
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_csr_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, csr_en, instr_retire;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] rdata, rdata2;
  logic        rvalid, rvalid2, illegal, illegal2;

  csr_unit #(.XLEN(32), .NUM_SCRATCH(4), .CNT_WIDTH(64), .HAS_INSTRET(1)) dut (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .instr_retire(instr_retire),
    .csr_rdata(rdata), .csr_rvalid(rvalid), .csr_illegal(illegal));

  // Narrow-counter variant without instret, driven by the same stimulus.
  csr_unit #(.XLEN(32), .NUM_SCRATCH(4), .CNT_WIDTH(32), .HAS_INSTRET(0)) dut32 (
    .clk(clk), .rst(rst), .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .instr_retire(instr_retire),
    .csr_rdata(rdata2), .csr_rvalid(rvalid2), .csr_illegal(illegal2));

  localparam logic [1:0] NONE = 2'd0, RW = 2'd1, SET = 2'd2, CLR = 2'd3;

  int checks = 0;
  int passed = 0;

  // Model of the 64-bit/instret configuration.
  longint unsigned m_cycle, m_instret;
  logic [31:0] m_scr [4];
  logic [31:0] e_rdata;
  logic        e_rvalid, e_illegal;

  function automatic void lookup(input logic [11:0] a, output bit mapped, output bit ro,
                                 output logic [31:0] old);
    mapped = 1'b1; ro = 1'b0; old = '0;
    if (a >= 12'h340 && a < 12'h344) old = m_scr[int'(a) - 'h340];
    else case (a)
      12'hB00: old = m_cycle[31:0];
      12'hB80: old = m_cycle[63:32];
      12'hB02: old = m_instret[31:0];
      12'hB82: old = m_instret[63:32];
      12'hC00: begin old = m_cycle[31:0];    ro = 1'b1; end
      12'hC80: begin old = m_cycle[63:32];   ro = 1'b1; end
      12'hC02: begin old = m_instret[31:0];  ro = 1'b1; end
      12'hC82: begin old = m_instret[63:32]; ro = 1'b1; end
      default: mapped = 1'b0;
    endcase
  endfunction

  function automatic void model_update(input logic r, input logic en, input logic [1:0] op,
                                       input logic [11:0] a, input logic [31:0] wd, input logic ret);
    bit mapped, ro, we, ill;
    logic [31:0] old, nv;
    longint unsigned nc, ni;
    if (r) begin
      m_cycle = 0; m_instret = 0;
      for (int i = 0; i < 4; i++) m_scr[i] = '0;
      e_rdata = '0; e_rvalid = 1'b0; e_illegal = 1'b0;
      return;
    end
    lookup(a, mapped, ro, old);
    we  = (op == RW) || ((op == SET || op == CLR) && wd != 0);
    ill = !mapped || (ro && we);
    nc  = m_cycle + 1;
    ni  = m_instret + (ret ? 1 : 0);
    if (en && !ill && we) begin
      nv = (op == RW) ? wd : (op == SET) ? (old | wd) : (old & ~wd);
      if (a >= 12'h340 && a < 12'h344) m_scr[int'(a) - 'h340] = nv;
      else if (a == 12'hB00) nc = {m_cycle[63:32], nv};
      else if (a == 12'hB80) nc = {nv, m_cycle[31:0]};
      else if (a == 12'hB02) ni = {m_instret[63:32], nv};
      else if (a == 12'hB82) ni = {nv, m_instret[31:0]};
    end
    m_cycle = nc; m_instret = ni;
    e_rvalid  = en;
    e_illegal = en && ill;
    if (en) e_rdata = ill ? 32'h0 : old;
  endfunction

  // One clock: drive at negedge, advance model at posedge, return at next negedge for sampling.
  task automatic step(input logic r, input logic en, input logic [1:0] op, input logic [11:0] a,
                      input logic [31:0] wd, input logic ret);
    rst = r; csr_en = en; csr_op = op; csr_addr = a; csr_wdata = wd; instr_retire = ret;
    @(posedge clk);
    model_update(r, en, op, a, wd, ret);
    @(negedge clk);
  endtask

  task automatic test_reset;
    step(1, 0, NONE, 12'h0, 32'h0, 0);
    step(1, 0, NONE, 12'h0, 32'h0, 0);
    checks++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", rvalid); else passed++;
    checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
  endtask

  task automatic test_scratch;
    step(0, 1, RW, 12'h340, 32'hDEADBEEF, 0);
    checks++; if (rvalid !== 1'b1) $display("FAIL scr_rvalid: got %b want 1", rvalid); else passed++;
    checks++; if (rdata !== 32'h0) $display("FAIL scr_first_rdata: got %h want 0", rdata); else passed++;
    checks++; if (illegal !== 1'b0) $display("FAIL scr_illegal: got %b want 0", illegal); else passed++;
    step(0, 1, NONE, 12'h340, 32'h0, 0);
    checks++; if (rdata !== 32'hDEADBEEF) $display("FAIL scr_readback: got %h want deadbeef", rdata); else passed++;
    step(0, 0, NONE, 12'h340, 32'h0, 0);
    checks++; if (rvalid !== 1'b0 || rdata !== 32'hDEADBEEF)
      $display("FAIL idle_hold: got rvalid=%b rdata=%h want 0/deadbeef", rvalid, rdata); else passed++;
  endtask

  task automatic test_set_clr;
    step(0, 1, RW, 12'h341, 32'h000000F0, 0);
    step(0, 1, SET, 12'h341, 32'h0F, 0);
    checks++; if (rdata !== 32'hF0) $display("FAIL set_old: got %h want f0", rdata); else passed++;
    step(0, 1, CLR, 12'h341, 32'h30, 0);
    checks++; if (rdata !== 32'hFF) $display("FAIL clr_old: got %h want ff", rdata); else passed++;
    step(0, 1, SET, 12'h341, 32'h0, 0);
    checks++; if (rdata !== 32'hCF) $display("FAIL set0_old: got %h want cf", rdata); else passed++;
    step(0, 1, NONE, 12'h341, 32'h0, 0);
    checks++; if (rdata !== 32'hCF) $display("FAIL set0_nochange: got %h want cf", rdata); else passed++;
  endtask

  task automatic test_counter_carry;
    step(0, 1, RW, 12'hB00, 32'hFFFFFFFE, 0);
    step(0, 0, NONE, 12'h0, 32'h0, 0);
    step(0, 0, NONE, 12'h0, 32'h0, 0);
    step(0, 1, NONE, 12'hB80, 32'h0, 0);
    checks++; if (rdata !== 32'h1) $display("FAIL carry_hi: got %h want 1", rdata); else passed++;
    step(0, 1, RW, 12'hB80, 32'hFFFFFFFF, 0);
    step(0, 1, RW, 12'hB00, 32'hFFFFFFFF, 0);
    step(0, 1, NONE, 12'hB00, 32'h0, 0);
    checks++; if (rdata !== 32'hFFFFFFFF) $display("FAIL preload_lo: got %h want ffffffff", rdata); else passed++;
    step(0, 1, NONE, 12'hB80, 32'h0, 0);
    checks++; if (rdata !== 32'h0) $display("FAIL wrap_hi: got %h want 0", rdata); else passed++;
    step(0, 1, NONE, 12'hB00, 32'h0, 0);
    checks++; if (rdata !== 32'h1) $display("FAIL wrap_lo: got %h want 1", rdata); else passed++;
  endtask

  task automatic test_write_vs_inc;
    step(0, 1, RW, 12'hB02, 32'h5, 1);
    step(0, 1, NONE, 12'hB02, 32'h0, 1);
    checks++; if (rdata !== 32'h5) $display("FAIL instret_written: got %h want 5", rdata); else passed++;
    step(0, 1, NONE, 12'hB02, 32'h0, 1);
    checks++; if (rdata !== 32'h6) $display("FAIL instret_resume: got %h want 6", rdata); else passed++;
    step(0, 1, NONE, 12'hB82, 32'h0, 1);
    checks++; if (rdata !== e_rdata) $display("FAIL instret_hi_hold: got %h want %h", rdata, e_rdata); else passed++;
    step(0, 0, NONE, 12'h0, 32'h0, 0);
  endtask

  task automatic test_illegal;
    step(0, 1, RW, 12'hC00, $urandom | 32'h1, 0);
    checks++; if (illegal !== 1'b1 || rdata !== 32'h0 || rvalid !== 1'b1)
      $display("FAIL ro_write: got ill=%b rdata=%h rv=%b want 1/0/1", illegal, rdata, rvalid); else passed++;
    step(0, 1, NONE, 12'hC00, 32'h0, 0);
    checks++; if (illegal !== 1'b0 || rdata !== e_rdata)
      $display("FAIL ro_read: got ill=%b rdata=%h want 0/%h", illegal, rdata, e_rdata); else passed++;
    step(0, 1, SET, 12'hC80, 32'h0, 0);
    checks++; if (illegal !== 1'b0 || rdata !== e_rdata)
      $display("FAIL ro_set0: got ill=%b rdata=%h want 0/%h", illegal, rdata, e_rdata); else passed++;
    step(0, 1, CLR, 12'hC02, 32'h4, 0);
    checks++; if (illegal !== 1'b1) $display("FAIL ro_clr: got %b want 1", illegal); else passed++;
    step(0, 1, RW, 12'h344, 32'h1234, 0);
    checks++; if (illegal !== 1'b1 || rdata !== 32'h0)
      $display("FAIL scr_oob: got ill=%b rdata=%h want 1/0", illegal, rdata); else passed++;
    step(0, 1, NONE, 12'hB80, 32'h0, 0);
    checks++; if (illegal2 !== 1'b1 || rdata2 !== 32'h0)
      $display("FAIL narrow_hi: got ill=%b rdata=%h want 1/0", illegal2, rdata2); else passed++;
    step(0, 1, NONE, 12'hB02, 32'h0, 0);
    checks++; if (illegal2 !== 1'b1) $display("FAIL no_instret: got %b want 1", illegal2); else passed++;
    step(0, 1, NONE, 12'hB00, 32'h0, 0);
    checks++; if (illegal2 !== 1'b0 || rvalid2 !== 1'b1)
      $display("FAIL narrow_lo: got ill=%b rv=%b want 0/1", illegal2, rvalid2); else passed++;
  endtask

  task automatic test_reset_mid;
    step(0, 1, RW, 12'h340, 32'hA5A5A5A5, 0);
    step(1, 1, RW, 12'h340, 32'h12345678, 0);
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h0)
      $display("FAIL rst_mid: got rv=%b rdata=%h want 0/0", rvalid, rdata); else passed++;
    step(0, 1, NONE, 12'h340, 32'h0, 0);
    checks++; if (rdata !== 32'h0 || rdata2 !== 32'h0)
      $display("FAIL rst_mid_scr: got %h/%h want 0/0", rdata, rdata2); else passed++;
  endtask

  task automatic test_random;
    logic [11:0] addrs [14];
    logic [11:0] a;
    logic [31:0] wd;
    addrs = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80,
              12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h34F};
    for (int n = 0; n < 400; n++) begin
      a  = ($urandom_range(0, 14) == 14) ? 12'($urandom) : addrs[$urandom_range(0, 13)];
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      step(($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0), 2'($urandom),
           a, wd, 1'($urandom));
      checks++; if (rvalid !== e_rvalid || illegal !== e_illegal || rdata !== e_rdata)
        $display("FAIL rand[%0d] addr=%h: got rv=%b ill=%b rdata=%h want %b/%b/%h",
                 n, a, rvalid, illegal, rdata, e_rvalid, e_illegal, e_rdata);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_scratch();
    test_set_clr();
    test_counter_carry();
    test_write_vs_inc();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Parametrised control/status register unit for the core. It executes csr_op_mode operations (NONE, READ_WRITE, SET, CLR) against an address-decoded register set.
- The register set holds NUM_SCRATCH scratch registers and two free-running counters, cycle and instret, each CNT_WIDTH wide.
- Each access returns the old CSR value one cycle later. The unit feeds the CSR leg of the writeback mux.

Parameters:
- XLEN, 32, data path width.
- NUM_SCRATCH, 4, number of RW scratch registers (1..16).
- CNT_WIDTH, 64, counter width. Legal range is 1..2*XLEN. When CNT_WIDTH > XLEN, a high half is exposed.
- HAS_INSTRET, 1, when 0 the instret counter and its addresses are absent and those addresses are illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- csr_en  in  1  access request this cycle.
- csr_op  in  2  0=NONE, 1=READ_WRITE, 2=SET, 3=CLR.
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  operand (rs1 value or zero-extended immediate).
- instr_retire  in  1  one instruction retired this cycle.
- csr_rdata  out  XLEN  old value of the accessed CSR, registered.
- csr_rvalid  out  1  one-cycle pulse, asserted in the cycle after an accepted access.
- csr_illegal  out  1  one-cycle pulse, aligned with csr_rvalid, flagging an illegal access.

Behaviour:
- Reset: when rst is high at a clock edge, the following clear to 0: all scratch registers, both counters, csr_rdata, csr_rvalid and csr_illegal. Reset mid-access drops the access: no write and no rvalid in the next cycle.
- Address map:
  - 0x340+i, for i < NUM_SCRATCH: scratch[i], RW.
  - 0xB00 / 0xB80: mcycle low / high, RW.
  - 0xB02 / 0xB82: minstret low / high, RW.
  - 0xC00 / 0xC80: cycle low / high, read-only shadow of mcycle.
  - 0xC02 / 0xC82: instret low / high, read-only shadow of minstret.
  - The high-half addresses exist only when CNT_WIDTH > XLEN. Otherwise they are unmapped.
- Low half = counter[min(CNT_WIDTH,XLEN)-1:0]. High half = counter[CNT_WIDTH-1:XLEN]. Unused upper bits read as 0 and are ignored on write.
- Access timing:
  - An access is sampled in cycle N when csr_en=1.
  - old = the value at the start of cycle N, before any cycle-N counter increment.
  - In cycle N+1: csr_rdata = old (or 0 if illegal), and csr_rvalid = 1.
  - A new access is accepted every cycle. Back-to-back accesses to the same CSR see the prior write.
- New value and write enable:
  - READ_WRITE: new = wdata, always writes.
  - SET: new = old | wdata, writes only if wdata != 0.
  - CLR: new = old & ~wdata, writes only if wdata != 0.
  - NONE: no write.
  - The write commits at the end of cycle N.
- Illegal accesses:
  - Unmapped address: illegal for any op. csr_rdata = 0, no state change.
  - Read-only address with a write-enabled op: illegal, no state change, csr_rdata = 0.
  - Read-only address with NONE, or with SET/CLR and wdata = 0: legal read.
- mcycle:
  - Increments by 1 every cycle when not in reset.
  - Wraps from 2^CNT_WIDTH-1 to 0.
- minstret:
  - Increments by 1 when instr_retire=1.
  - Wraps the same way as mcycle.
- Simultaneous write and increment to the same counter: the write wins for the written half. The other half holds its start-of-cycle value, with no carry propagated that cycle. The counter resumes incrementing from the written value in the next cycle.
- When csr_en=0: csr_rvalid=0 and csr_illegal=0 in the next cycle. csr_rdata holds its last value.

Test Plan:
- Reset, then scratch access:
  - Assert rst for 2 cycles, then READ_WRITE 0x340 with wdata=0xDEADBEEF. Expect rvalid, rdata=0, illegal=0 the next cycle.
  - Follow with NONE 0x340. Expect rdata=0xDEADBEEF.
- Set/clear on scratch:
  - Start with scratch[1]=0x0000_00F0.
  - SET 0x341 with wdata=0x0F. Expect rdata=0xF0, and the register becomes 0xFF.
  - CLR 0x341 with wdata=0x30. Expect rdata=0xFF, and the register becomes 0xCF.
  - SET 0x341 with wdata=0. Expect no change.
- Counter carry and wrap:
  - READ_WRITE 0xB00 with wdata=0xFFFF_FFFE (high half = 0).
  - Two cycles later, read 0xB80. Expect 1, i.e. carry into the high half.
  - Preload 0xB80=0xFFFF_FFFF and 0xB00=0xFFFF_FFFF. The counter reads low=0, high=0 after one cycle.
- Write versus increment:
  - Assert instr_retire continuously.
  - READ_WRITE 0xB02 with wdata=5. In the next cycle minstret low=5 and high unchanged; in the cycle after, low=6.
- Illegal accesses:
  - READ_WRITE 0xC00: expect illegal=1, rdata=0, mcycle undisturbed.
  - NONE 0xC00: expect legal, rdata equals the mcycle value.
  - Access 0x340+NUM_SCRATCH (0x344): expect illegal=1.
  - With CNT_WIDTH=32, access 0xB80: expect illegal=1.
- Reset mid-access:
  - Issue READ_WRITE 0x340 in the same cycle that rst=1.
  - Next cycle: rvalid=0, and scratch[0] reads 0 afterwards.
